roll_sequencer: RTL

- Timing controller for the Lab1 random-number datapath: on a start request it issues a decelerating series of single-cycle advance pulses to the LFSR, then a single done pulse that the display/store logic uses to latch the final value.
- Implements the "fast spin, then slow to a stop" roll effect in one place, replacing free-running counters inside Top.
- Also supports an early stop and a restart while a roll is in progress.

---
 rtl/roll_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/roll_sequencer.sv
// Roll timing controller: on a start edge, issues a decelerating series of
// single-cycle LFSR advance ticks, then one done pulse for capturing the result.
module roll_sequencer #(
    parameter int CNT_W       = 24,
    parameter int INIT_PERIOD = 1000,
    parameter int STEP        = 500,
    parameter int MAX_PERIOD  = 5000000,
    parameter int NUM_TICKS   = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic                             i_stop,
    output logic                             o_tick,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [$clog2(NUM_TICKS+1)-1:0]   o_tick_cnt
);

    localparam int TC_W = $clog2(NUM_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [TC_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic              start_q, start_d;

    logic              start_edge;
    logic              tick_hit;
    logic [TC_W-1:0]   tick_cnt_inc;
    logic [CNT_W:0]    period_sum;

    assign start_edge   = i_start & ~start_q;
    assign tick_hit     = (cnt_q == period_q - CNT_W'(1));
    assign tick_cnt_inc = tick_cnt_q + 1'b1;
    // One extra bit so the step addition cannot wrap before saturation.
    assign period_sum   = {1'b0, period_q} + (CNT_W+1)'(STEP);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= CNT_W'(INIT_PERIOD);
            tick_cnt_q <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            tick_cnt_q <= tick_cnt_d;
            start_q    <= start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        tick_cnt_d = tick_cnt_q;
        start_d    = i_start;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    period_d   = CNT_W'(INIT_PERIOD);
                    tick_cnt_d = '0;
                end
            end
            S_RUN: begin
                // Restart outranks stop, which outranks the pending tick.
                if (start_edge) begin
                    cnt_d      = '0;
                    period_d   = CNT_W'(INIT_PERIOD);
                    tick_cnt_d = '0;
                end else if (i_stop) begin
                    state_d = S_DONE;
                end else if (tick_hit) begin
                    cnt_d      = '0;
                    tick_cnt_d = tick_cnt_inc;
                    if (period_sum > (CNT_W+1)'(MAX_PERIOD))
                        period_d = CNT_W'(MAX_PERIOD);
                    else
                        period_d = period_sum[CNT_W-1:0];
                    if (tick_cnt_inc == TC_W'(NUM_TICKS))
                        state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_tick = 1'b0;
        case (state_q)
            S_RUN: begin
                o_busy = 1'b1;
                o_tick = tick_hit & ~start_edge & ~i_stop;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_tick_cnt = tick_cnt_q;

endmodule
